// File: rtl/rv32_mod_load_store_unit.sv
// RV32 load/store unit: single outstanding word-wide bus access with extended load data and fault code.
// Optional feature macro MISALIGNED_SPLIT_EN: misaligned legal-size accesses are split into two bus words.
module rv32_mod_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [3:0]        req_func,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACCESS2, S_RESP} state_t;

  localparam logic [1:0] F_OK      = 2'b00;
  localparam logic [1:0] F_ALIGN   = 2'b01;
  localparam logic [1:0] F_BUS     = 2'b10;
  localparam logic [1:0] F_TIMEOUT = 2'b11;

  state_t      r_state;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_wr;
  logic        r_split;
  logic [31:0] r_wait;
  logic [31:0] r_rdata1;
  logic [31:0] r_wdata2;
  logic [3:0]  r_be2;

  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic        w_illegal;
  logic        w_mis;
  logic        w_reject;
  logic        w_split;
  logic [3:0]  w_szmask;
  logic [3:0]  w_be_al;
  logic [7:0]  w_mask8;
  logic [63:0] w_wdata64;
  logic [31:0] w_wdata_rep;
  logic [63:0] w_ld_src;
  logic [31:0] w_ld_sh;
  logic [31:0] w_ld;
  logic        w_timeout;
  logic        w_unused;

  assign w_size    = req_func[1:0];
  assign w_off     = req_addr[1:0];
  assign w_illegal = (w_size == 2'b11);
  assign w_mis     = ((w_size == 2'b01) && w_off[0]) || ((w_size == 2'b10) && (w_off != 2'b00));
  assign w_unused  = req_func[3];

`ifdef MISALIGNED_SPLIT_EN
  assign w_reject = w_illegal;
  assign w_split  = w_mis;
`else
  assign w_reject = w_illegal || w_mis;
  assign w_split  = 1'b0;
`endif

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_szmask    = 4'b0001;
    w_be_al     = 4'b0001 << w_off;
    w_wdata_rep = {4{req_wdata[7:0]}};
    case (w_size)
      2'b01: begin
        w_szmask    = 4'b0011;
        w_be_al     = 4'b0011 << {w_off[1], 1'b0};
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10, 2'b11: begin
        w_szmask    = 4'b1111;
        w_be_al     = 4'b1111;
        w_wdata_rep = req_wdata;
      end
      default: ;
    endcase
    // Split accesses use the 8-lane view: low half drives part 1, high half part 2.
    w_mask8   = {4'b0000, w_szmask} << w_off;
    w_wdata64 = {32'h0, req_wdata} << {w_off, 3'b000};
  end

  always_comb begin
    w_ld_src = (r_state == S_ACCESS2) ? {mem_rdata, r_rdata1} : {32'h0, mem_rdata};
    w_ld_sh  = 32'(w_ld_src >> {r_off, 3'b000});
    case (r_size)
      2'b00:   w_ld = {{24{~r_uns & w_ld_sh[7]}}, w_ld_sh[7:0]};
      2'b01:   w_ld = {{16{~r_uns & w_ld_sh[15]}}, w_ld_sh[15:0]};
      default: w_ld = w_ld_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_fault <= F_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_wr      <= 1'b0;
      r_split   <= 1'b0;
      r_wait    <= '0;
      r_rdata1  <= '0;
      r_wdata2  <= '0;
      r_be2     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_off     <= w_off;
            r_size    <= w_size;
            r_uns     <= req_func[2];
            r_wr      <= req_wr;
            r_split   <= w_split;
            r_wait    <= '0;
            r_be2     <= w_mask8[7:4];
            r_wdata2  <= w_wdata64[63:32];
            if (w_reject) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= F_ALIGN;
              rsp_rdata <= '0;
            end else begin
              r_state   <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_wr;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= w_split ? w_mask8[3:0] : w_be_al;
              mem_wdata <= w_split ? w_wdata64[31:0] : w_wdata_rep;
            end
          end
        end
        S_ACCESS, S_ACCESS2: begin
          if (mem_ack) begin
            r_wait <= '0;
            if (!mem_err && r_split && (r_state == S_ACCESS)) begin
              r_state   <= S_ACCESS2;
              r_rdata1  <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_be    <= r_be2;
              mem_wdata <= r_wdata2;
            end else begin
              r_state   <= S_RESP;
              mem_req   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_fault <= mem_err ? F_BUS : F_OK;
              rsp_rdata <= (mem_err || r_wr) ? '0 : w_ld;
            end
          end else if (w_timeout) begin
            r_state   <= S_RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_fault <= F_TIMEOUT;
            rsp_rdata <= '0;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// Self-checking bench for rv32_mod_load_store_unit: literal scenarios plus randomized transactions
// against a byte-lane transaction model.
module tb_rv32_mod_load_store_unit;
  localparam int unsigned TO = 4;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [3:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32_mod_load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_func(req_func),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_fault"}, rsp_fault, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Called at a negedge with the LSU idle; returns at the negedge after the response pulse.
  task automatic run_txn(input logic wr, input logic [3:0] func, input logic [31:0] addr,
                         input logic [31:0] wd, input int d0, input int d1,
                         input logic e0, input logic e1, input logic [31:0] rd0, input logic [31:0] rd1,
                         output logic [31:0] ob_addr, output logic [3:0] ob_be, output logic [31:0] ob_wd,
                         output logic [31:0] o_rdata, output logic [1:0] o_fault);
    int size, off, nbytes, nbeats, lane;
    int dl[2];
    bit mis, rej, split, done;
    logic er[2];
    logic [31:0] rdv[2];
    logic [31:0] ad_e[2];
    logic [31:0] wd_e[2];
    logic [3:0]  be_e[2];
    logic [31:0] lm, exp_rd;
    logic [1:0]  exp_f;
    size   = int'(func[1:0]);
    off    = int'(addr[1:0]);
    nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    mis    = (off % nbytes) != 0;
    rej    = (size == 3) || (mis && !SPLIT);
    split  = !rej && mis;
    nbeats = rej ? 0 : (split ? 2 : 1);
    dl[0] = d0; dl[1] = d1; er[0] = e0; er[1] = e1; rdv[0] = rd0; rdv[1] = rd1;
    ad_e[0] = addr & 32'hFFFF_FFFC;
    ad_e[1] = ad_e[0] + 32'd4;
    be_e[0] = '0; be_e[1] = '0; wd_e[0] = '0; wd_e[1] = '0;
    for (int k = 0; k < nbytes; k++) begin
      lane = off + k;
      be_e[lane / 4][lane % 4] = 1'b1;
      wd_e[lane / 4][8 * (lane % 4) +: 8] = wd[8 * k +: 8];
    end
    if (!split)
      for (int l = 0; l < 4; l++) wd_e[0][8 * l +: 8] = wd[8 * (l % nbytes) +: 8];
    exp_f = rej ? 2'b01 : 2'b00;
    for (int b = 0; b < nbeats; b++)
      if (exp_f == 2'b00) begin
        if (dl[b] >= int'(TO)) exp_f = 2'b11;
        else if (er[b]) exp_f = 2'b10;
      end
    exp_rd = '0;
    for (int k = 0; k < nbytes; k++) begin
      lane = off + k;
      exp_rd[8 * k +: 8] = rdv[lane / 4][8 * (lane % 4) +: 8];
    end
    if (nbytes < 4 && !func[2] && exp_rd[8 * nbytes - 1])
      for (int k = nbytes; k < 4; k++) exp_rd[8 * k +: 8] = 8'hFF;
    if (wr || exp_f != 2'b00) exp_rd = '0;

    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_func = func; req_addr = addr; req_wdata = wd;
    mem_ack = 1'($urandom); mem_err = 1'($urandom); mem_rdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0; req_wr = 1'($urandom); req_func = 4'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    mem_ack = 1'b0;
    ob_addr = '0; ob_be = '0; ob_wd = '0; done = 1'b0;
    for (int b = 0; b < nbeats && !done; b++) begin
      for (int j = 0; j < int'(TO); j++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, ad_e[b]);
        chk("mem_we", mem_we, wr);
        chk("mem_be", mem_be, be_e[b]);
        for (int l = 0; l < 4; l++) lm[8 * l +: 8] = {8{be_e[b][l]}};
        if (split) chk("mem_wdata_lanes", mem_wdata & lm, wd_e[b] & lm);
        else       chk("mem_wdata", mem_wdata, wd_e[b]);
        chk("rsp_quiet", rsp_valid, 0);
        chk("ready_busy", req_ready, 0);
        if (b == 0 && j == 0) begin
          ob_addr = mem_addr; ob_be = mem_be; ob_wd = mem_wdata;
        end
        if (j == dl[b]) begin
          mem_ack = 1'b1; mem_err = er[b]; mem_rdata = rdv[b];
          @(negedge clk);
          mem_ack = 1'b0; mem_err = 1'($urandom); mem_rdata = $urandom;
          if (er[b]) done = 1'b1;
          break;
        end
        mem_err = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        if (j == int'(TO) - 1) done = 1'b1;
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_fault", rsp_fault, exp_f);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("mem_req_dropped", mem_req, 0);
    chk("ready_in_resp", req_ready, 0);
    o_rdata = rsp_rdata; o_fault = rsp_fault;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_resp", req_ready, 1);
  endtask

  logic [31:0] a_addr, a_wd, a_rd;
  logic [3:0]  a_be;
  logic [1:0]  a_f;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_func = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 4'b0000, 32'h103, 32'h0, 0, 0, 1'b0, 1'b0, 32'h80FF_FF00, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("lb_be", a_be, 4'b1000);
    chk("lb_rdata", a_rd, 32'hFFFF_FF80);
    chk("lb_fault", a_f, 2'b00);

    run_txn(1'b0, 4'b0101, 32'h102, 32'h0, 1, 0, 1'b0, 1'b0, 32'hBEEF_1234, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("lhu_be", a_be, 4'b1100);
    chk("lhu_rdata", a_rd, 32'h0000_BEEF);

    run_txn(1'b1, 4'b0000, 32'h201, 32'h1234_56AB, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("sb_addr", a_addr, 32'h200);
    chk("sb_be", a_be, 4'b0010);
    chk("sb_wdata", a_wd, 32'hABAB_ABAB);
    chk("sb_rdata", a_rd, 32'h0);

    run_txn(1'b0, 4'b1001, 32'h6, 32'h0, 0, 0, 1'b0, 1'b0, 32'h8001_0000, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("lh_be", a_be, 4'b1100);
    chk("lh_rdata", a_rd, 32'hFFFF_8001);

    run_txn(1'b0, 4'b0010, 32'h102, 32'h0, 0, 0, 1'b0, 1'b0, 32'h4433_2211, 32'h8877_6655,
            a_addr, a_be, a_wd, a_rd, a_f);
    if (SPLIT) begin
      chk("lw_split_addr", a_addr, 32'h100);
      chk("lw_split_rdata", a_rd, 32'h6655_4433);
      chk("lw_split_fault", a_f, 2'b00);
    end else begin
      chk("lw_mis_fault", a_f, 2'b01);
      chk("lw_mis_rdata", a_rd, 32'h0);
    end

    run_txn(1'b0, 4'b0010, 32'h40, 32'h0, 99, 0, 1'b0, 1'b0, 32'h1111_1111, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("timeout_fault", a_f, 2'b11);

    run_txn(1'b0, 4'b0010, 32'h44, 32'h0, 1, 0, 1'b1, 1'b0, 32'h2222_2222, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("buserr_fault", a_f, 2'b10);
    chk("buserr_rdata", a_rd, 32'h0);

    req_valid = 1'b1; req_wr = 1'b0; req_func = 4'b0010; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_req0", mem_req, 1);
    @(negedge clk);
    chk("rst_mid_req1", mem_req, 1);
    rstn = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rstn = 1'b1;
    @(negedge clk);
    chk("stray_ack_rsp", rsp_valid, 0);
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_ready", req_ready, 1);
    mem_ack = 1'b0;

    run_txn(1'b0, 4'b0010, 32'h10, 32'h0, 2, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0,
            a_addr, a_be, a_wd, a_rd, a_f);
    chk("post_rst_rdata", a_rd, 32'hCAFE_F00D);
    chk("post_rst_fault", a_f, 2'b00);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra;
      int rd0, rd1;
      logic re0, re1;
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra[31:3] = '1;
      rd0 = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
      rd1 = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
      re0 = ($urandom_range(0, 7) == 0);
      re1 = ($urandom_range(0, 7) == 0);
      run_txn(1'($urandom), 4'($urandom), ra, $urandom, rd0, rd1, re0, re1, $urandom, $urandom,
              a_addr, a_be, a_wd, a_rd, a_f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_mod_load_store_unit.md
Name: rv32_mod_load_store_unit

Overview:
Executes RV32 loads and stores for the core. It sits directly downstream of the instruction decoder: it consumes the decoder's `ram_req` and `ram_wr` controls, the ALU-computed effective address and the rs2 store data. It drives a single-outstanding word-wide memory bus and returns sign- or zero-extended load data to the `WB_SOURCE_LSU` writeback path, with a fault code.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for `mem_ack` before aborting with a timeout fault; 0 disables the timeout.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  request from decode/execute
- req_ready  out  1  LSU can accept a request
- req_wr  in  1  1 = store (decoder `ram_wr`), 0 = load
- req_func  in  4  decoder `ram_req`; [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] unsigned; [3] ignored
- req_addr  in  ADDR_W  effective byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  2  00 ok, 01 misaligned/illegal size, 10 bus error, 11 timeout
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address, [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  access complete this cycle
- mem_rdata  in  32  read data, valid with `mem_ack`
- mem_err  in  1  bus error, valid with `mem_ack`

Behaviour:
- Reset: when rstn is low at a clock edge, the state returns to IDLE. All outputs go to 0 except `req_ready`, which is 1. Any in-flight access is dropped and `mem_req` is low the cycle after reset is sampled. No response is issued for a dropped access.
- States: IDLE, ACCESS, ACCESS2 (split only), RESP.
- IDLE:
  - `req_ready` = 1.
  - A request is accepted on `req_valid` && `req_ready`, and the address, function and data are registered.
  - Illegal size, or misaligned access (half with a[0] = 1; word with a[1:0] != 0): go to RESP with fault 01. No bus cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_req` = 1.
  - `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable until `mem_ack`.
  - Byte enables: byte `4'b0001 << a[1:0]`; half `4'b0011 << {a[1],1'b0}`; word `4'b1111`.
  - Store data: byte replicated as 4 × wdata[7:0]; half as 2 × wdata[15:0]; word unchanged.
  - On `mem_ack`: capture `mem_rdata`; if `mem_err`, fault 10. Then go to RESP.
  - Wait counter increments each non-ack cycle. On reaching TIMEOUT_CYCLES: drop `mem_req`, fault 11, go to RESP.
- RESP:
  - `rsp_valid` = 1 for exactly one cycle, then IDLE.
  - `req_ready` = 0 during ACCESS, ACCESS2 and RESP.
- Load data: shift `mem_rdata` right by 8·a[1:0], then extend from bit 7 (byte) or bit 15 (half). Unsigned loads zero-extend.
- Latency:
  - Request accepted at edge T; `mem_req` high from T+1.
  - Ack in cycle T+1 gives `rsp_valid` in T+2.
  - Back-to-back: next accept at T+3.
- No response backpressure: writeback must take `rsp_valid` when it is asserted.
- `mem_ack` while `mem_req` = 0 is ignored.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined:
  - Misaligned legal-size accesses are split into two bus cycles: ACCESS at word a>>2, then ACCESS2 at (a>>2)+1. The address wraps modulo 2^ADDR_W.
  - Byte enables are the low and high portions of the 8-lane shifted mask.
  - Load data: {rdata2, rdata1} >> 8·a[1:0], then extended.
  - A fault in part 1 skips part 2. A store's part-1 write is not undone.
  - The timeout counter restarts for part 2.
- Undefined: misaligned accesses produce fault 01 as specified above. ACCESS2 is absent.

Test Plan:
- LB, addr 0x103, `mem_rdata` 0x80FF_FF00, ack in 1st cycle → `mem_be` 1000, `rsp_rdata` 0xFFFF_FF80, fault 00, `rsp_valid` at T+2.
- LHU, addr 0x102, `mem_rdata` 0xBEEF_1234 → `mem_be` 1100, `rsp_rdata` 0x0000_BEEF.
- SB, addr 0x201, wdata 0x1234_56AB → `mem_we` 1, `mem_be` 0010, `mem_wdata` 0xABAB_ABAB, `mem_addr` 0x200, `rsp_rdata` 0.
- LW, addr 0x102:
  - Without split → no `mem_req`, fault 01 at T+1.
  - With split, rdata 0x4433_2211 then 0x8877_6655 → two requests at 0x100 and 0x104, `rsp_rdata` 0x6655_4433.
- TIMEOUT_CYCLES = 4, ack never asserted → `mem_req` high exactly 4 cycles then low, fault 11. `mem_err` with ack → fault 10.
- rstn low during ACCESS → `mem_req` = 0 the next cycle, no `rsp_valid`, `req_ready` = 1; a new request is then serviced normally.
